// File: rtl/lsu_arb_pkg.sv
// Shared constants, port indices, arbiter state and request payload type for the LSU D-cache port arbiter.
package lsu_arb_pkg;

  localparam int unsigned NR_PORTS        = 3;
  localparam int unsigned ADDR_WIDTH      = 34;
  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned BE_WIDTH        = DATA_WIDTH / 8;
  localparam int unsigned MAX_OUTSTANDING = 4;
  localparam int unsigned PORT_W          = $clog2(NR_PORTS);
  localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING) + 1;

  localparam int unsigned PORT_STORE = 0;
  localparam int unsigned PORT_LOAD  = 1;
  localparam int unsigned PORT_AMO   = 2;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
  } mem_req_t;

  // Round-robin successor of a port index.
  function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] p);
    return (p == PORT_W'(NR_PORTS - 1)) ? '0 : p + PORT_W'(1);
  endfunction

endpackage

// File: rtl/lsu_id_fifo.sv
// In-order queue of requester IDs for reads awaiting a D-cache response.
module lsu_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];
  assign pop_ok  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok = push_i & (~full_o | pop_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      if (pop_ok) rptr_q <= rptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lsu_dcache_port_arbiter.sv
// Round-robin arbiter sharing one D-cache port among LSU requesters; locks until granted
// and routes in-order read responses back to the issuing port.
module lsu_dcache_port_arbiter
  import lsu_arb_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NR_PORTS-1:0]            req_i,
  input  logic [NR_PORTS-1:0]            we_i,
  input  logic [NR_PORTS*ADDR_WIDTH-1:0] addr_i,
  input  logic [NR_PORTS*DATA_WIDTH-1:0] wdata_i,
  input  logic [NR_PORTS*BE_WIDTH-1:0]   be_i,
  output logic [NR_PORTS-1:0]            gnt_o,
  output logic [NR_PORTS-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [ADDR_WIDTH-1:0]          mem_addr_o,
  output logic [DATA_WIDTH-1:0]          mem_wdata_o,
  output logic [BE_WIDTH-1:0]            mem_be_o,
  input  logic                           mem_gnt_i,
  input  logic                           mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]          mem_rdata_i,
  output logic                           busy_o,
  output logic                           proto_err_o
);

  arb_state_e          state_q, state_d;
  logic [PORT_W-1:0]   lock_port_q, lock_port_d;
  logic [PORT_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PORT_W-1:0]   rr_sel, scan_idx, sel;
  logic                rr_found, req_c, grant, push, pop;
  logic [NR_PORTS-1:0] eligible;
  mem_req_t            port_req [NR_PORTS];
  mem_req_t            sel_req;
  logic                fifo_full, fifo_empty;
  logic [PORT_W-1:0]   fifo_head;
  logic [CNT_W-1:0]    fifo_count;
  logic                proto_err_q;

  // Unpack per-port payloads; reads are only eligible while a queue slot is free.
  always_comb begin
    for (int k = 0; k < int'(NR_PORTS); k++) begin
      port_req[k].we    = we_i[k];
      port_req[k].addr  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      port_req[k].wdata = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      port_req[k].be    = be_i[k*BE_WIDTH +: BE_WIDTH];
      eligible[k]       = req_i[k] & (we_i[k] | ~fifo_full);
    end
  end

  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    scan_idx = rr_ptr_q;
    for (int i = 0; i < int'(NR_PORTS); i++) begin
      if (!rr_found && eligible[scan_idx]) begin
        rr_found = 1'b1;
        rr_sel   = scan_idx;
      end
      scan_idx = next_port(scan_idx);
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_port_d = lock_port_q;
    rr_ptr_d    = rr_ptr_q;
    sel         = rr_sel;
    req_c       = rr_found;
    case (state_q)
      ARB_LOCKED: begin
        sel   = lock_port_q;
        req_c = 1'b1;
      end
      default: ;
    endcase
    if (req_c) begin
      if (mem_gnt_i) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = next_port(sel);
      end else begin
        state_d     = ARB_LOCKED;
        lock_port_d = sel;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ARB_IDLE;
      lock_port_q <= '0;
      rr_ptr_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_port_q <= lock_port_d;
      rr_ptr_q    <= rr_ptr_d;
      if (mem_rvalid_i && fifo_empty) proto_err_q <= 1'b1;
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign sel_req     = port_req[sel];
  assign mem_req_o   = rst_ni & req_c;
  assign grant       = mem_req_o & mem_gnt_i;
  assign mem_we_o    = mem_req_o & sel_req.we;
  assign mem_addr_o  = mem_req_o ? sel_req.addr : '0;
  assign mem_wdata_o = mem_req_o ? sel_req.wdata : '0;
  assign mem_be_o    = mem_req_o ? sel_req.be : '0;
  assign gnt_o       = grant ? (NR_PORTS'(1) << sel) : '0;
  assign push        = grant & ~sel_req.we;
  assign pop         = rst_ni & mem_rvalid_i & ~fifo_empty;
  assign rvalid_o    = pop ? (NR_PORTS'(1) << fifo_head) : '0;
  assign rdata_o     = rst_ni ? mem_rdata_i : '0;
  assign busy_o      = (fifo_count != '0);
  assign proto_err_o = proto_err_q;

  lsu_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (PORT_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (sel),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_lsu_dcache_port_arbiter.sv
// Directed bench for the LSU D-cache port arbiter: grant order, locking, response routing, queue limits, errors.
module tb_lsu_dcache_port_arbiter;

  logic         clk_i;
  logic         rst_ni;
  logic [2:0]   req_i, we_i;
  logic [101:0] addr_i;
  logic [95:0]  wdata_i;
  logic [11:0]  be_i;
  logic [2:0]   gnt_o, rvalid_o;
  logic [31:0]  rdata_o;
  logic         mem_req_o, mem_we_o;
  logic [33:0]  mem_addr_o;
  logic [31:0]  mem_wdata_o;
  logic [3:0]   mem_be_o;
  logic         mem_gnt_i, mem_rvalid_i;
  logic [31:0]  mem_rdata_i;
  logic         busy_o, proto_err_o;

  int checks = 0;
  int errors = 0;

  localparam logic [33:0] ADDR0 = 34'h2_0000_0000;
  localparam logic [33:0] ADDR1 = 34'h2_0000_0100;
  localparam logic [33:0] ADDR2 = 34'h2_0000_0200;

  lsu_dcache_port_arbiter dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .be_i         (be_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .busy_o       (busy_o),
    .proto_err_o  (proto_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then let combinational outputs settle.
  task automatic step(input logic [2:0] r, input logic [2:0] w, input logic g, input logic rv);
    @(negedge clk_i);
    req_i        = r;
    we_i         = w;
    mem_gnt_i    = g;
    mem_rvalid_i = rv;
    #1;
  endtask

  initial begin
    addr_i      = {ADDR2, ADDR1, ADDR0};
    wdata_i     = {32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    be_i        = {4'hC, 4'h3, 4'hF};
    mem_rdata_i = 32'h1234_5678;

    // Reset with live inputs: every output must stay low.
    rst_ni = 1'b0; req_i = 3'b111; we_i = 3'b000; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    #2;
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_rvalid", 64'(rvalid_o), 64'd0);
    chk("rst_rdata", 64'(rdata_o), 64'd0);
    chk("rst_addr", 64'(mem_addr_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_proto_err", 64'(proto_err_o), 64'd0);
    @(negedge clk_i);
    req_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; rst_ni = 1'b1;

    // Ports 0,1 read from rr_ptr=0, then all-write proves rr_ptr reached 2.
    step(3'b011, 3'b000, 1'b1, 1'b0);
    chk("t1_gnt0", 64'(gnt_o), 64'b001);
    chk("t1_addr0", 64'(mem_addr_o), 64'(ADDR0));
    chk("t1_we0", 64'(mem_we_o), 64'd0);
    step(3'b010, 3'b000, 1'b1, 1'b0);
    chk("t1_gnt1", 64'(gnt_o), 64'b010);
    chk("t1_addr1", 64'(mem_addr_o), 64'(ADDR1));
    step(3'b111, 3'b111, 1'b1, 1'b0);
    chk("t1_gnt_rr2", 64'(gnt_o), 64'b100);
    chk("t1_wdata2", 64'(mem_wdata_o), 64'h2222_2222);
    chk("t1_be2", 64'(mem_be_o), 64'hC);
    step(3'b000, 3'b000, 1'b0, 1'b0);
    chk("t1_busy", 64'(busy_o), 64'd1);
    chk("t1_idle_req", 64'(mem_req_o), 64'd0);
    chk("t1_idle_addr", 64'(mem_addr_o), 64'd0);
    step(3'b000, 3'b000, 1'b0, 1'b1);
    chk("t1_rv0", 64'(rvalid_o), 64'b001);
    chk("t1_rdata", 64'(rdata_o), 64'h1234_5678);
    step(3'b000, 3'b000, 1'b0, 1'b1);
    chk("t1_rv1", 64'(rvalid_o), 64'b010);
    step(3'b000, 3'b000, 1'b0, 1'b0);
    chk("t1_busy_clr", 64'(busy_o), 64'd0);

    // Lock on port 1 while port 0 arrives; then a lock held after req drops.
    step(3'b010, 3'b000, 1'b0, 1'b0);
    chk("t2_req", 64'(mem_req_o), 64'd1);
    chk("t2_addr_c0", 64'(mem_addr_o), 64'(ADDR1));
    chk("t2_gnt_c0", 64'(gnt_o), 64'd0);
    step(3'b011, 3'b000, 1'b0, 1'b0);
    chk("t2_addr_c1", 64'(mem_addr_o), 64'(ADDR1));
    chk("t2_gnt_c1", 64'(gnt_o), 64'd0);
    step(3'b011, 3'b000, 1'b0, 1'b0);
    chk("t2_addr_c2", 64'(mem_addr_o), 64'(ADDR1));
    step(3'b011, 3'b000, 1'b1, 1'b0);
    chk("t2_gnt_lock", 64'(gnt_o), 64'b010);
    chk("t2_addr_gnt", 64'(mem_addr_o), 64'(ADDR1));
    step(3'b001, 3'b000, 1'b1, 1'b0);
    chk("t2_gnt_p0", 64'(gnt_o), 64'b001);
    step(3'b100, 3'b000, 1'b0, 1'b0);
    chk("t2_addr_p2", 64'(mem_addr_o), 64'(ADDR2));
    step(3'b000, 3'b000, 1'b1, 1'b0);
    chk("t2_drop_req", 64'(mem_req_o), 64'd1);
    chk("t2_drop_gnt", 64'(gnt_o), 64'b100);
    step(3'b000, 3'b000, 1'b0, 1'b1);
    chk("t2_rv_a", 64'(rvalid_o), 64'b010);
    step(3'b000, 3'b000, 1'b0, 1'b1);
    chk("t2_rv_b", 64'(rvalid_o), 64'b001);
    step(3'b000, 3'b000, 1'b0, 1'b1);
    chk("t2_rv_c", 64'(rvalid_o), 64'b100);
    step(3'b000, 3'b000, 1'b0, 1'b0);
    chk("t2_busy_clr", 64'(busy_o), 64'd0);

    // Reads from ports 2,0,1 return in issue order.
    step(3'b100, 3'b000, 1'b1, 1'b0);
    chk("t3_gnt2", 64'(gnt_o), 64'b100);
    step(3'b001, 3'b000, 1'b1, 1'b0);
    chk("t3_gnt0", 64'(gnt_o), 64'b001);
    step(3'b010, 3'b000, 1'b1, 1'b0);
    chk("t3_gnt1", 64'(gnt_o), 64'b010);
    step(3'b000, 3'b000, 1'b0, 1'b1);
    chk("t3_rv2", 64'(rvalid_o), 64'b100);
    step(3'b000, 3'b000, 1'b0, 1'b1);
    chk("t3_rv0", 64'(rvalid_o), 64'b001);
    chk("t3_busy_mid", 64'(busy_o), 64'd1);
    step(3'b000, 3'b000, 1'b0, 1'b1);
    chk("t3_rv1", 64'(rvalid_o), 64'b010);
    chk("t3_busy_last", 64'(busy_o), 64'd1);
    step(3'b000, 3'b000, 1'b0, 1'b0);
    chk("t3_busy_clr", 64'(busy_o), 64'd0);

    // Fill the queue; writes pass, reads wait on the registered count.
    step(3'b100, 3'b000, 1'b1, 1'b0);
    chk("t4_fill_a", 64'(gnt_o), 64'b100);
    step(3'b001, 3'b000, 1'b1, 1'b0);
    chk("t4_fill_b", 64'(gnt_o), 64'b001);
    step(3'b010, 3'b000, 1'b1, 1'b0);
    chk("t4_fill_c", 64'(gnt_o), 64'b010);
    step(3'b100, 3'b000, 1'b1, 1'b0);
    chk("t4_fill_d", 64'(gnt_o), 64'b100);
    step(3'b011, 3'b001, 1'b1, 1'b0);
    chk("t4_wr_gnt", 64'(gnt_o), 64'b001);
    chk("t4_wr_we", 64'(mem_we_o), 64'd1);
    chk("t4_wr_data", 64'(mem_wdata_o), 64'hDEAD_BEEF);
    chk("t4_wr_be", 64'(mem_be_o), 64'hF);
    step(3'b010, 3'b000, 1'b1, 1'b0);
    chk("t4_full_req", 64'(mem_req_o), 64'd0);
    chk("t4_full_gnt", 64'(gnt_o), 64'd0);
    step(3'b010, 3'b000, 1'b1, 1'b1);
    chk("t4_pop_rv", 64'(rvalid_o), 64'b100);
    chk("t4_pop_blocked", 64'(gnt_o), 64'd0);
    step(3'b010, 3'b000, 1'b1, 1'b0);
    chk("t4_after_pop", 64'(gnt_o), 64'b010);
    step(3'b000, 3'b000, 1'b0, 1'b1);
    chk("t4_rv_p0", 64'(rvalid_o), 64'b001);
    step(3'b100, 3'b000, 1'b1, 1'b1);
    chk("t4_pp_gnt", 64'(gnt_o), 64'b100);
    chk("t4_pp_rv", 64'(rvalid_o), 64'b010);
    step(3'b010, 3'b000, 1'b1, 1'b0);
    chk("t4_pp_cnt3", 64'(gnt_o), 64'b010);
    step(3'b001, 3'b000, 1'b1, 1'b0);
    chk("t4_full_again", 64'(gnt_o), 64'd0);
    step(3'b000, 3'b000, 1'b0, 1'b1);
    chk("t4_drain_a", 64'(rvalid_o), 64'b100);
    step(3'b000, 3'b000, 1'b0, 1'b1);
    chk("t4_drain_b", 64'(rvalid_o), 64'b010);
    step(3'b000, 3'b000, 1'b0, 1'b1);
    chk("t4_drain_c", 64'(rvalid_o), 64'b100);
    step(3'b000, 3'b000, 1'b0, 1'b1);
    chk("t4_drain_d", 64'(rvalid_o), 64'b010);
    step(3'b000, 3'b000, 1'b0, 1'b0);
    chk("t4_busy_clr", 64'(busy_o), 64'd0);

    // Response with empty queue sets a sticky error; reset clears state mid-flight.
    step(3'b000, 3'b000, 1'b0, 1'b1);
    chk("t5_empty_rv", 64'(rvalid_o), 64'd0);
    step(3'b000, 3'b000, 1'b0, 1'b0);
    chk("t5_perr_set", 64'(proto_err_o), 64'd1);
    step(3'b001, 3'b000, 1'b1, 1'b0);
    chk("t5_gnt0", 64'(gnt_o), 64'b001);
    chk("t5_perr_sticky", 64'(proto_err_o), 64'd1);
    step(3'b010, 3'b000, 1'b1, 1'b0);
    chk("t5_gnt1", 64'(gnt_o), 64'b010);
    step(3'b000, 3'b000, 1'b0, 1'b0);
    chk("t5_busy", 64'(busy_o), 64'd1);
    @(negedge clk_i);
    rst_ni = 1'b0; req_i = 3'b001; mem_gnt_i = 1'b1;
    #1;
    chk("t5_rst_busy", 64'(busy_o), 64'd0);
    chk("t5_rst_perr", 64'(proto_err_o), 64'd0);
    chk("t5_rst_req", 64'(mem_req_o), 64'd0);
    chk("t5_rst_gnt", 64'(gnt_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1; req_i = '0; mem_gnt_i = 1'b0;
    step(3'b000, 3'b000, 1'b0, 1'b1);
    chk("t5_stale_rv", 64'(rvalid_o), 64'd0);
    step(3'b000, 3'b000, 1'b0, 1'b0);
    chk("t5_stale_perr", 64'(proto_err_o), 64'd1);
    chk("t5_stale_busy", 64'(busy_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
